// File: rtl/decoder_pkg.sv
// Shared types for the decoder pipeline: decode-mode and buffer-occupancy enums.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_INV    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_comb.sv
// Combinational code-to-word decoder (one-hot / thermometer / inverted one-hot).
// The err_o port and its logic exist only when DECODER_RANGE_CHK_EN is defined.
module decoder_comb
  import decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  code_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o
`ifdef DECODER_RANGE_CHK_EN
  ,
  output logic             err_o
`endif
);

  mode_e       w_mode;
  logic [31:0] w_code;
  logic        w_in_range;

  assign w_mode     = mode_e'(mode_i);
  assign w_code     = 32'(code_i);
  assign w_in_range = (w_code < 32'(OUT_W));

  always_comb begin
    data_o = '0;
    for (int b = 0; b < OUT_W; b++) begin
      case (w_mode)
        MODE_ONEHOT: data_o[b] = (w_code == 32'(b));
        MODE_THERM:  data_o[b] = (w_code >= 32'(b));
        MODE_INV:    data_o[b] = (w_code != 32'(b));
        default:     data_o[b] = 1'b0;
      endcase
    end
    // Codes that name a bit beyond the output word decode to nothing.
    if (!w_in_range) data_o = '0;
  end

`ifdef DECODER_RANGE_CHK_EN
  assign err_o = (w_mode == MODE_RSVD) || !w_in_range;
`endif

endmodule

// File: rtl/decoder_pipe.sv
// Decoder with a two-entry (output + skid) valid/ready buffer and an accept counter.
// Define DECODER_RANGE_CHK_EN to flag reserved modes and out-of-range codes on err_o.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  decoder_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] decoder_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  state_e           r_state, w_state_next;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_out_data, r_skid_data, w_dec_data;
  logic [CNT_W-1:0] r_count;
  logic             w_accept, w_drain;
  logic             w_load_out, w_load_skid, w_out_from_skid;

`ifdef DECODER_RANGE_CHK_EN
  logic w_dec_err, r_out_err, r_skid_err;
`endif

  decoder_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_decoder_comb (
    .code_i (decoder_i),
    .mode_i (mode_i),
    .data_o (w_dec_data)
`ifdef DECODER_RANGE_CHK_EN
    ,
    .err_o  (w_dec_err)
`endif
  );

  assign w_accept = in_valid_i && r_in_ready;
  assign w_drain  = out_valid_o && out_ready_i;

  // in_ready is registered from the next state, so out_ready_i never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_TWO);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_ONE;
      ST_ONE: begin
        if (w_accept && !w_drain)      w_state_next = ST_TWO;
        else if (!w_accept && w_drain) w_state_next = ST_EMPTY;
      end
      ST_TWO:   if (w_drain) w_state_next = ST_ONE;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid_o     = (r_state != ST_EMPTY);
    in_ready_o      = r_in_ready;
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: w_load_out = w_accept;
      ST_ONE: begin
        w_load_out  = w_accept && w_drain;
        w_load_skid = w_accept && !w_drain;
      end
      ST_TWO: begin
        w_load_out      = w_drain;
        w_out_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
`ifdef DECODER_RANGE_CHK_EN
      r_out_err   <= 1'b0;
      r_skid_err  <= 1'b0;
`endif
    end else begin
      if (w_load_out) begin
        r_out_data <= w_out_from_skid ? r_skid_data : w_dec_data;
`ifdef DECODER_RANGE_CHK_EN
        r_out_err  <= w_out_from_skid ? r_skid_err : w_dec_err;
`endif
      end
      if (w_load_skid) begin
        r_skid_data <= w_dec_data;
`ifdef DECODER_RANGE_CHK_EN
        r_skid_err  <= w_dec_err;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_count <= '0;
    else if (w_accept) r_count <= r_count + CNT_W'(1);
  end

  assign decoder_o = r_out_data;
  assign count_o   = r_count;
`ifdef DECODER_RANGE_CHK_EN
  assign err_o = r_out_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe: a default instance (OUT_W=16, CNT_W=16) and a
// narrow instance (OUT_W=10, CNT_W=4) driven with directed and $urandom stimulus.
module tb_decoder_pipe;

`ifdef DECODER_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      in_valid, out_ready;
  logic [1:0][3:0] code;
  logic [1:0][1:0] mode;
  logic            rdy0, rdy1, ov0, ov1, err0, err1;
  logic [15:0]     dec0, cnt0;
  logic [9:0]      dec1;
  logic [3:0]      cnt1;

  decoder_pipe #(.IN_W(4), .OUT_W(16), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(rdy0),
    .decoder_i(code[0]), .mode_i(mode[0]), .out_valid_o(ov0), .out_ready_i(out_ready[0]),
    .decoder_o(dec0), .err_o(err0), .count_o(cnt0)
  );

  decoder_pipe #(.IN_W(4), .OUT_W(10), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(rdy1),
    .decoder_i(code[1]), .mode_i(mode[1]), .out_valid_o(ov1), .out_ready_i(out_ready[1]),
    .decoder_o(dec1), .err_o(err1), .count_o(cnt1)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  int          acc_cnt[2];

  function automatic logic f_ready(int k);  return (k == 0) ? rdy0 : rdy1; endfunction
  function automatic logic f_valid(int k);  return (k == 0) ? ov0 : ov1; endfunction
  function automatic logic f_err(int k);    return (k == 0) ? err0 : err1; endfunction
  function automatic logic [15:0] f_dec(int k); return (k == 0) ? dec0 : {6'b0, dec1}; endfunction
  function automatic logic [15:0] f_cnt(int k); return (k == 0) ? cnt0 : {12'b0, cnt1}; endfunction

  // Expected {err, word} from the decode rules, using plain integer arithmetic.
  function automatic logic [16:0] ref_dec(int k, int c, int m);
    int     ow;
    longint d;
    bit     e;
    ow = (k == 0) ? 16 : 10;
    d  = 0;
    e  = 1'b0;
    if (m == 3)       e = CHK;
    else if (c >= ow) e = CHK;
    else if (m == 0)  d = longint'(1) << c;
    else if (m == 1)  d = (longint'(1) << (c + 1)) - 1;
    else              d = ((longint'(1) << ow) - 1) ^ (longint'(1) << c);
    return {e, 16'(d)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+2: presents inputs for the coming edge and records an accept.
  task automatic drive(int k, bit v, int c, int m, output bit acc);
    in_valid[k] = v;
    code[k]     = 4'(c);
    mode[k]     = 2'(m);
    acc         = v && f_ready(k);
    if (acc) begin
      if (k == 0) q0.push_back(ref_dec(k, c, m));
      else        q1.push_back(ref_dec(k, c, m));
      acc_cnt[k]++;
      $display("issue  inst%0d code=%0d mode=%0d", k, c, m);
    end
  endtask

  task automatic send(int k, int c, int m);
    bit a;
    int n;
    n = 0;
    drive(k, 1'b1, c, m, a);
    @(posedge clk); #2;
    while (!a && n < 50) begin
      drive(k, 1'b1, c, m, a);
      @(posedge clk); #2;
      n++;
    end
    if (!a) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout inst%0d: actual=not_accepted required=accepted", k);
    end
  endtask

  task automatic idle();
    in_valid = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic check_count(int k);
    int unsigned m;
    m = (k == 0) ? 32'hFFFF : 32'hF;
    check($sformatf("count%0d", k), 32'(f_cnt(k)), 32'(acc_cnt[k]) & m);
  endtask

  task automatic check_reset(int k);
    check($sformatf("rst_valid%0d", k), 32'(f_valid(k)), 32'd0);
    check($sformatf("rst_ready%0d", k), 32'(f_ready(k)), 32'd1);
    check($sformatf("rst_dec%0d", k),   32'(f_dec(k)),   32'd0);
    check($sformatf("rst_err%0d", k),   32'(f_err(k)),   32'd0);
    check($sformatf("rst_cnt%0d", k),   32'(f_cnt(k)),   32'd0);
  endtask

  // Monitor: pops on every output handshake and checks hold stability under backpressure.
  logic [16:0] held[2];
  bit          held_v[2];
  initial begin
    logic [16:0] cur, exp;
    held_v[0] = 1'b0;
    held_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n || !f_valid(k)) begin
          held_v[k] = 1'b0;
        end else begin
          cur = {f_err(k), f_dec(k)};
          if (held_v[k]) check($sformatf("hold%0d", k), 32'(cur), 32'(held[k]));
          if (out_ready[k]) begin
            held_v[k] = 1'b0;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_out%0d: actual=0x%0h required=no_output", k, cur);
            end else begin
              exp = (k == 0) ? q0.pop_front() : q1.pop_front();
              $display("output inst%0d word=0x%0h err=%0d", k, cur[15:0], cur[16]);
              check($sformatf("out%0d", k), 32'(cur), 32'(exp));
            end
          end else begin
            held_v[k] = 1'b1;
            held[k]   = cur;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    rst_n = 1'b1; in_valid = 2'b00; out_ready = 2'b00; code = '0; mode = '0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    #3 rst_n = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // One-hot sweep, back-to-back with the sink always ready.
    out_ready = 2'b11;
    for (int c = 0; c < 16; c++) send(0, c, 0);
    idle();
    drain();
    check("sweep_count", 32'(cnt0), 32'd16);

    // Remaining modes with code 5.
    send(0, 5, 1); send(0, 5, 2); send(0, 5, 3);
    idle();
    drain();

    // Backpressure: two accepts fill the buffer.
    out_ready[0] = 1'b0;
    send(0, 3, 0); send(0, 7, 0);
    idle();
    check("bp_ready", 32'(rdy0), 32'd0);
    check("bp_valid", 32'(ov0), 32'd1);
    check("bp_dec", 32'(dec0), 32'h0008);
    repeat (3) @(posedge clk);
    #2;
    check("bp_dec_held", 32'(dec0), 32'h0008);
    out_ready[0] = 1'b1;
    drain();

    // Out-of-range codes on the narrow instance.
    send(1, 12, 0); send(1, 9, 2); send(1, 15, 1); send(1, 9, 1);
    idle();
    drain();

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        out_ready[k] = ($urandom_range(0, 3) != 0);
        drive(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), a);
      end
      @(posedge clk); #2;
    end
    idle();
    out_ready = 2'b11;
    drain();
    check_count(0);
    check_count(1);

    // Reset while the buffer holds two entries.
    out_ready[0] = 1'b0;
    send(0, 2, 0); send(0, 4, 0);
    idle();
    check("pre_rst_ready", 32'(rdy0), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ov0), 32'd0);
    check("midrst_count", 32'(cnt0), 32'd0);
    check("midrst_ready", 32'(rdy0), 32'd1);
    check("midrst_dec", 32'(dec0), 32'd0);
    q0.delete(); q1.delete();
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 2'b11;
    send(0, 1, 0);
    idle();
    drain();
    check("post_rst_count", 32'(cnt0), 32'd1);

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) send(1, int'($urandom_range(0, 9)), 0);
    idle();
    drain();
    check("wrap_count", 32'(cnt1), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 4, meaning code width.
REQ-002 SHALL have parameter OUT_W, default 16, meaning output width; legal range 2..2**IN_W.
REQ-003 SHALL have parameter CNT_W, default 16, meaning accepted-transaction counter width.
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 SHALL have ports as follows:
- clk  input  1  clock.
- rst_n  input  1  async active-low reset.
- in_valid_i  input  1  input transaction valid.
- in_ready_o  output  1  block can accept.
- decoder_i  input  IN_W  code.
- mode_i  input  2  00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved.
- out_valid_o  output  1  output valid.
- out_ready_i  input  1  downstream accepts.
- decoder_o  output  OUT_W  decoded word.
- err_o  output  1  error flag travelling with decoder_o.
- count_o  output  CNT_W  accepted-input count.

Function
REQ-006 SHALL accept an input on any clk edge where in_valid_i && in_ready_o, sampling decoder_i and mode_i together.
REQ-007 SHALL decode as follows, for code c:
- one-hot: bit c set.
- thermometer: bits 0..c set.
- inverted one-hot: all bits set except bit c.
- reserved mode: all zero, err=1.
REQ-008 SHALL have latency 1: an input accepted at edge k SHALL be presented on decoder_o/out_valid_o after edge k when the buffer was empty.
REQ-009 SHALL buffer two entries (output register plus skid register), with states EMPTY, ONE and TWO.
REQ-010 SHALL make these state transitions:
- EMPTY: accept -> ONE.
- ONE: accept without drain -> TWO; drain without accept -> EMPTY; accept and drain together -> ONE.
- TWO: drain -> ONE, with skid moving to output.
REQ-011 SHALL drive in_ready_o = (state != TWO), registered, with no combinational path from out_ready_i.
REQ-012 SHALL hold decoder_o and err_o stable while out_valid_o && !out_ready_i.
REQ-013 SHALL deliver entries in acceptance order, with no loss or duplication.
REQ-014 SHALL increment count_o by 1 per accepted input, wrapping 2**CNT_W-1 -> 0.
REQ-015 SHALL drive out_valid_o = (state != EMPTY).

Reset
REQ-016 SHALL, on rst_n low, immediately force state EMPTY, out_valid_o=0, in_ready_o=1, decoder_o=0, err_o=0, count_o=0.
REQ-017 SHALL discard buffered entries on reset mid-operation; the first edge after release SHALL accept normally.

Configuration
REQ-018 SHALL, with DECODER_RANGE_CHK_EN defined, treat a code c >= OUT_W as out-of-range: decoder_o all zero, err=1.
REQ-019 SHALL, without DECODER_RANGE_CHK_EN, give out-of-range codes decoder_o all zero, tie err_o to 0, and remove the error logic; reserved mode SHALL still yield zero.

Structure
REQ-020 SHALL place the mode enum (MODE_ONEHOT, MODE_THERM, MODE_INV, MODE_RSVD) and the state enum in package decoder_pkg.
REQ-021 SHALL implement the combinational decode in sub-module decoder_comb (IN_W, OUT_W), instantiated once at the input side.

Verification
REQ-022 SHALL cover a sweep with out_ready_i=1, mode 00, codes 0..15 back-to-back -> decoder_o 0x0001..0x8000 one cycle later each, count_o=16.
REQ-023 SHALL cover modes with code 5: mode 01 -> 0x003F; mode 10 -> 0xFFDF; mode 11 -> 0x0000 with err_o=1 (when DECODER_RANGE_CHK_EN is defined).
REQ-024 SHALL cover backpressure: out_ready_i=0 with codes 3 then 7 accepted -> in_ready_o=0 after the second; decoder_o holds 0x0008; releasing out_ready_i yields 0x0008 then 0x0080.
REQ-025 SHALL cover out-of-range with OUT_W=10: code 12, mode 00 -> decoder_o=0x000; err_o=1 if the macro is defined, else 0.
REQ-026 SHALL cover reset mid-operation: rst_n low while state TWO -> out_valid_o=0, count_o=0 immediately; after release, code 1 -> 0x0002.
REQ-027 SHALL cover wrap with CNT_W=4: 17 accepts -> count_o=1.
